// File: rtl/axis_hdr_arbiter.sv
// axis_hdr_arbiter: packet-granular round-robin arbiter feeding one header-insertion
// datapath from N AXI-Stream sources. A grant is held from arbitration until the
// granted packet's TLAST handshake, so every beat and sidechannel of a packet comes
// from one source. The data path is a purely combinational mux on the registered grant.
module axis_hdr_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 8,
    parameter int IDX_W      = $clog2(N_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]   src_TDATA,
    input  logic [N_INPUTS*DATA_WIDTH/8-1:0] src_TKEEP,
    input  logic [N_INPUTS-1:0]              src_TLAST,
    input  logic [N_INPUTS*DEST_WIDTH-1:0]   src_TDEST,
    input  logic [N_INPUTS*ID_WIDTH-1:0]     src_TID,
    input  logic [N_INPUTS*USER_WIDTH-1:0]   src_TUSER,
    input  logic [N_INPUTS-1:0]              src_TVALID,
    output logic [N_INPUTS-1:0]              src_TREADY,
    input  logic [N_INPUTS-1:0]              en_mask,
    output logic [DATA_WIDTH-1:0]            arb_TDATA,
    output logic [DATA_WIDTH/8-1:0]          arb_TKEEP,
    output logic                             arb_TLAST,
    output logic [DEST_WIDTH-1:0]            arb_TDEST,
    output logic [ID_WIDTH-1:0]              arb_TID,
    output logic [USER_WIDTH-1:0]            arb_TUSER,
    output logic                             arb_TVALID,
    input  logic                             arb_TREADY,
    output logic                             grant_vld,
    output logic [IDX_W-1:0]                 grant_idx
);

    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    last_idx;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic [N_INPUTS-1:0] elig;
    logic                last_hs;

    // Only sources that are both requesting and enabled may win a new grant.
    assign elig    = src_TVALID & en_mask;
    assign last_hs = arb_TVALID & arb_TREADY & arb_TLAST;

    // Round-robin search starting just above the previous winner; walking the
    // offsets downward lets the nearest eligible source overwrite farther ones.
    always_comb begin
        pick = last_idx;
        cand = last_idx;
        for (int k = N_INPUTS; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % N_INPUTS);
            if (elig[cand]) begin
                pick = cand;
            end
        end
    end

    // Output mux follows grant_idx even when idle so the waveform does not glitch;
    // valid and ready are only opened while a grant is held.
    always_comb begin
        arb_TDATA  = '0;
        arb_TKEEP  = '0;
        arb_TLAST  = 1'b0;
        arb_TDEST  = '0;
        arb_TID    = '0;
        arb_TUSER  = '0;
        arb_TVALID = 1'b0;
        src_TREADY = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                arb_TDATA     = src_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                arb_TKEEP     = src_TKEEP[i*KEEP_W +: KEEP_W];
                arb_TLAST     = src_TLAST[i];
                arb_TDEST     = src_TDEST[i*DEST_WIDTH +: DEST_WIDTH];
                arb_TID       = src_TID[i*ID_WIDTH +: ID_WIDTH];
                arb_TUSER     = src_TUSER[i*USER_WIDTH +: USER_WIDTH];
                arb_TVALID    = grant_vld & src_TVALID[i];
                src_TREADY[i] = grant_vld & arb_TREADY;
            end
        end
    end

    // Grant FSM: lock onto a source in ARB, release it on the TLAST handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            last_idx  <= IDX_W'(N_INPUTS - 1);
        end else begin
            case (state)
                ARB: begin
                    if (|elig) begin
                        grant_idx <= pick;
                        grant_vld <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (last_hs) begin
                        last_idx  <= grant_idx;
                        grant_vld <= 1'b0;
                        state     <= ARB;
                    end
                end
                default: begin
                    grant_vld <= 1'b0;
                    state     <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_hdr_arbiter.sv
// Testbench for axis_hdr_arbiter: per-source beat queues drive the inputs, expected
// beats are queued in predicted grant order and checked as they leave the arbiter.
module tb_axis_hdr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int SW = 16;
    localparam int IW = 16;
    localparam int UW = 8;
    localparam int XW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] src_TDATA;
    logic [N*KW-1:0] src_TKEEP;
    logic [N-1:0]    src_TLAST;
    logic [N*SW-1:0] src_TDEST;
    logic [N*IW-1:0] src_TID;
    logic [N*UW-1:0] src_TUSER;
    logic [N-1:0]    src_TVALID;
    logic [N-1:0]    src_TREADY;
    logic [N-1:0]    en_mask;
    logic [DW-1:0]   arb_TDATA;
    logic [KW-1:0]   arb_TKEEP;
    logic            arb_TLAST;
    logic [SW-1:0]   arb_TDEST;
    logic [IW-1:0]   arb_TID;
    logic [UW-1:0]   arb_TUSER;
    logic            arb_TVALID;
    logic            arb_TREADY;
    logic            grant_vld;
    logic [XW-1:0]   grant_idx;

    always #5 clk = ~clk;

    axis_hdr_arbiter #(
        .N_INPUTS(N), .DATA_WIDTH(DW), .DEST_WIDTH(SW), .ID_WIDTH(IW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .src_TDATA(src_TDATA), .src_TKEEP(src_TKEEP), .src_TLAST(src_TLAST),
        .src_TDEST(src_TDEST), .src_TID(src_TID), .src_TUSER(src_TUSER),
        .src_TVALID(src_TVALID), .src_TREADY(src_TREADY), .en_mask(en_mask),
        .arb_TDATA(arb_TDATA), .arb_TKEEP(arb_TKEEP), .arb_TLAST(arb_TLAST),
        .arb_TDEST(arb_TDEST), .arb_TID(arb_TID), .arb_TUSER(arb_TUSER),
        .arb_TVALID(arb_TVALID), .arb_TREADY(arb_TREADY),
        .grant_vld(grant_vld), .grant_idx(grant_idx)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [SW-1:0] dest;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic [XW-1:0] src;
    } beat_t;

    beat_t       srcq [N][$];
    beat_t       expq [$];
    beat_t       e;
    logic [N-1:0] gap;
    int          n_pass  = 0;
    int          n_total = 0;

    // Scoreboard: every accepted output beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && arb_TVALID && arb_TREADY) begin
            n_total++;
            if (expq.size() == 0) begin
                $display("FAIL sb_unexpected: got beat data=%h from src %0d, required no beat", arb_TDATA, grant_idx);
            end else begin
                e = expq.pop_front();
                if ({arb_TDATA, arb_TKEEP, arb_TLAST, arb_TDEST, arb_TID, arb_TUSER, grant_idx} !==
                    {e.data, e.keep, e.last, e.dest, e.id, e.user, e.src})
                    $display("FAIL sb_beat: got src=%0d data=%h keep=%h last=%b dest=%h id=%h user=%h, required src=%0d data=%h keep=%h last=%b dest=%h id=%h user=%h",
                             grant_idx, arb_TDATA, arb_TKEEP, arb_TLAST, arb_TDEST, arb_TID, arb_TUSER,
                             e.src, e.data, e.keep, e.last, e.dest, e.id, e.user);
                else
                    n_pass++;
            end
        end
    end

    task automatic add_pkt(input int s, input int p, input int nb, input bit sb);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data = {8'(s), 8'(p), 16'(k), 32'hC0DE_0000 ^ 32'(p * 7 + k)};
            b.keep = (k == nb - 1) ? 8'h0F : 8'hFF;
            b.last = (k == nb - 1);
            b.dest = {8'(s), 8'(p)};
            b.id   = 16'(p * 3 + 1);
            b.user = 8'(k + s * 16);
            b.src  = XW'(s);
            srcq[s].push_back(b);
            if (sb) expq.push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && !gap[i]) begin
                b = srcq[i][0];
                src_TVALID[i] = 1'b1;
            end else begin
                b = '0;
                src_TVALID[i] = 1'b0;
            end
            src_TDATA[i*DW +: DW] = b.data;
            src_TKEEP[i*KW +: KW] = b.keep;
            src_TLAST[i]          = b.last;
            src_TDEST[i*SW +: SW] = b.dest;
            src_TID[i*IW +: IW]   = b.id;
            src_TUSER[i*UW +: UW] = b.user;
        end
    endtask

    // One clock: note handshakes before the edge, retire those beats after it.
    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = src_TVALID & src_TREADY;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive();
    endtask

    task automatic clear_all();
        expq.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
        gap = '0;
        drive();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        arb_TREADY = 1'b1;
        en_mask    = '1;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        arb_TREADY = 1'b1;
        en_mask    = '1;
        gap        = '0;
        for (int s = 0; s < N; s++) add_pkt(s, 1, 1, 1'b0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (grant_vld !== 1'b0) $display("FAIL rst_grant_vld: got %b, required 0", grant_vld); else n_pass++;
        n_total++; if (grant_idx !== 2'd0) $display("FAIL rst_grant_idx: got %0d, required 0", grant_idx); else n_pass++;
        n_total++; if (arb_TVALID !== 1'b0) $display("FAIL rst_arb_tvalid: got %b, required 0", arb_TVALID); else n_pass++;
        n_total++; if (src_TREADY !== 4'b0) $display("FAIL rst_src_tready: got %b, required 0000", src_TREADY); else n_pass++;
        clear_all();
    endtask

    task automatic test_single_source();
        do_reset();
        add_pkt(2, 5, 3, 1'b1);
        drive();
        n_total++; if (grant_vld !== 1'b0) $display("FAIL single_arb_idle: got grant_vld=%b, required 0", grant_vld); else n_pass++;
        tick();
        n_total++; if (grant_idx !== 2'd2) $display("FAIL single_grant_idx: got %0d, required 2", grant_idx); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({grant_vld, arb_TVALID} !== 2'b11)
                $display("FAIL single_beat%0d_valid: got grant_vld,arb_TVALID=%b, required 11", k, {grant_vld, arb_TVALID});
            else n_pass++;
            tick();
        end
        n_total++; if (grant_vld !== 1'b0) $display("FAIL single_release: got grant_vld=%b, required 0", grant_vld); else n_pass++;
        n_total++; if (expq.size() != 0) $display("FAIL single_drain: got %0d beats outstanding, required 0", expq.size()); else n_pass++;
    endtask

    task automatic test_round_robin();
        int cyc  = 0;
        int leak = 0;
        logic [N-1:0] own;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_pkt(s, 10 + r * 4 + s, 2, 1'b1);
        drive();
        while (expq.size() > 0 && cyc < 100) begin
            own = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
            if ((src_TREADY & ~own) != 4'b0) leak++;
            tick();
            cyc++;
        end
        n_total++; if (cyc != 24) $display("FAIL rr_cycles: got %0d cycles for 8 two-beat packets, required 24", cyc); else n_pass++;
        n_total++; if (leak != 0) $display("FAIL rr_tready_leak: got %0d cycles with foreign TREADY, required 0", leak); else n_pass++;
    endtask

    task automatic test_back_pressure();
        int j = 0;
        do_reset();
        add_pkt(1, 30, 4, 1'b1);
        drive();
        tick();
        while (expq.size() > 0 && j < 30) begin
            arb_TREADY = (j % 2 == 0);
            gap[1]     = (j == 4 || j == 5);
            drive();
            #1;
            n_total++;
            if ({grant_vld, grant_idx, src_TREADY} !== {1'b1, 2'd1, 2'b00, arb_TREADY, 1'b0})
                $display("FAIL bp_hold_cycle%0d: got vld=%b idx=%0d tready=%b, required vld=1 idx=1 tready=00%b0",
                         j, grant_vld, grant_idx, src_TREADY, arb_TREADY);
            else n_pass++;
            tick();
            j++;
        end
        arb_TREADY = 1'b1;
        gap        = '0;
        n_total++; if (j != 9) $display("FAIL bp_cycles: got %0d cycles, required 9", j); else n_pass++;
        n_total++; if (grant_vld !== 1'b0) $display("FAIL bp_release: got grant_vld=%b, required 0", grant_vld); else n_pass++;
    endtask

    task automatic test_mask();
        int cyc = 0;
        do_reset();
        add_pkt(1, 20, 1, 1'b1);
        drive();
        tick();
        n_total++; if (grant_idx !== 2'd1) $display("FAIL mask_pre_grant: got %0d, required 1", grant_idx); else n_pass++;
        tick();
        add_pkt(3, 21, 3, 1'b1);
        add_pkt(0, 22, 1, 1'b1);
        add_pkt(1, 23, 1, 1'b1);
        add_pkt(2, 24, 1, 1'b0);
        en_mask = 4'b1011;
        drive();
        tick();
        n_total++; if ({grant_vld, grant_idx} !== {1'b1, 2'd3}) $display("FAIL mask_skip: got vld=%b idx=%0d, required vld=1 idx=3", grant_vld, grant_idx); else n_pass++;
        en_mask = 4'b0011;
        while (expq.size() > 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        repeat (2) tick();
        n_total++; if (expq.size() != 0) $display("FAIL mask_drain: got %0d beats outstanding, required 0", expq.size()); else n_pass++;
        n_total++; if (grant_vld !== 1'b0) $display("FAIL mask_src2_blocked: got grant_vld=%b idx=%0d, required 0", grant_vld, grant_idx); else n_pass++;
        n_total++; if (srcq[2].size() != 1) $display("FAIL mask_src2_pending: got %0d beats left, required 1", srcq[2].size()); else n_pass++;
        en_mask = '1;
    endtask

    task automatic test_wrap_single_beat();
        int cyc = 0;
        do_reset();
        add_pkt(0, 50, 1, 1'b1);
        add_pkt(3, 51, 1, 1'b1);
        add_pkt(0, 52, 1, 1'b1);
        drive();
        tick(); cyc++;
        n_total++; if (grant_idx !== 2'd0) $display("FAIL wrap_first: got %0d, required 0", grant_idx); else n_pass++;
        tick(); cyc++;
        n_total++; if (grant_vld !== 1'b0) $display("FAIL wrap_turnaround: got grant_vld=%b, required 0", grant_vld); else n_pass++;
        tick(); cyc++;
        n_total++; if (grant_idx !== 2'd3) $display("FAIL wrap_second: got %0d, required 3", grant_idx); else n_pass++;
        while (expq.size() > 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_total++; if (cyc != 6) $display("FAIL wrap_cycles: got %0d cycles, required 6", cyc); else n_pass++;
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        do_reset();
        add_pkt(2, 40, 4, 1'b1);
        drive();
        tick();
        tick();
        n_total++; if ({grant_vld, arb_TVALID, src_TREADY} !== 6'b11_0100) $display("FAIL areset_pre: got vld,tvalid,tready=%b, required 110100", {grant_vld, arb_TVALID, src_TREADY}); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (arb_TVALID !== 1'b0) $display("FAIL areset_tvalid: got %b, required 0", arb_TVALID); else n_pass++;
        n_total++; if (src_TREADY !== 4'b0) $display("FAIL areset_tready: got %b, required 0000", src_TREADY); else n_pass++;
        n_total++; if ({grant_vld, grant_idx} !== 3'b0) $display("FAIL areset_grant: got vld=%b idx=%0d, required 0 0", grant_vld, grant_idx); else n_pass++;
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_pkt(0, 42, 1, 1'b1);
        add_pkt(2, 41, 1, 1'b1);
        drive();
        tick();
        n_total++; if ({grant_vld, grant_idx} !== {1'b1, 2'd0}) $display("FAIL areset_first_grant: got vld=%b idx=%0d, required 1 0", grant_vld, grant_idx); else n_pass++;
        while (expq.size() > 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_total++; if (expq.size() != 0) $display("FAIL areset_drain: got %0d beats outstanding, required 0", expq.size()); else n_pass++;
    endtask

    initial begin
        rst        = 1'b1;
        gap        = '0;
        en_mask    = '1;
        arb_TREADY = 1'b1;
        src_TVALID = '0;
        test_reset();
        test_single_source();
        test_round_robin();
        test_back_pressure();
        test_mask();
        test_wrap_single_beat();
        test_async_reset();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
